// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART command responder.
package uart_pkg;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        SEND,
        HOLD,
        WAIT
    } resp_state_t;

endpackage

// File: rtl/uart_regfile.sv
// Control register file: synchronous write, combinational read, clears on reset.
module uart_regfile #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic [7:0] mem [NUM_REGS];

    // Storage update: synchronous active-low clear, then single write port.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mem <= '{default: 8'h00};
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_cmd_responder.sv
// Parses W/R register-access commands from UART bytes and sends one response byte per command.
module uart_cmd_responder
    import uart_pkg::*;
#(
    parameter int unsigned ADDR_W         = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic              rx_fail,
    input  logic              tx_busy,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              timeout_err,
    output logic              overrun
);

    localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    resp_state_t       state_q, state_d;
    logic              cmd_wr_q, cmd_wr_d;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] rx_addr;
    logic [7:0]        rd_data;
    logic              addr_ok;
    logic              tmo;
    logic              tmo_fire;
    logic              addr_load;
    logic              wr_en;
    logic              rsp_load;
    logic [7:0]        rsp_d;
    logic              ovr_set;

    assign rx_addr = rx_data[ADDR_W-1:0];
    assign addr_ok = ((rx_data >> ADDR_W) == 8'h00);
    assign tmo     = (cnt_q == CNT_LAST);

    // Read port looks at the incoming addr byte so a read samples it in its rx_done cycle.
    uart_regfile #(
        .ADDR_W(ADDR_W)
    ) u_regfile (
        .clock (clock),
        .reset (reset),
        .we    (wr_en),
        .waddr (addr_q),
        .wdata (rx_data),
        .raddr (rx_addr),
        .rdata (rd_data)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, response selection and one-cycle control strobes; rx_fail beats rx_done.
    always_comb begin
        state_d   = state_q;
        cmd_wr_d  = cmd_wr_q;
        addr_load = 1'b0;
        wr_en     = 1'b0;
        rsp_load  = 1'b0;
        rsp_d     = RSP_NAK;
        ovr_set   = 1'b0;
        tmo_fire  = 1'b0;
        tx_start  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx_fail) begin
                    rsp_load = 1'b1;
                    state_d  = SEND;
                end else if (rx_done) begin
                    if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                        cmd_wr_d = (rx_data == CMD_WR);
                        state_d  = GET_ADDR;
                    end else begin
                        rsp_load = 1'b1;
                        state_d  = SEND;
                    end
                end
            end
            GET_ADDR: begin
                if (rx_fail) begin
                    rsp_load = 1'b1;
                    state_d  = SEND;
                end else if (rx_done) begin
                    if (!addr_ok) begin
                        rsp_load = 1'b1;
                        state_d  = SEND;
                    end else if (cmd_wr_q) begin
                        addr_load = 1'b1;
                        state_d   = GET_DATA;
                    end else begin
                        rsp_load = 1'b1;
                        rsp_d    = rd_data;
                        state_d  = SEND;
                    end
                end else if (tmo) begin
                    tmo_fire = 1'b1;
                    state_d  = IDLE;
                end
            end
            GET_DATA: begin
                if (rx_fail) begin
                    rsp_load = 1'b1;
                    state_d  = SEND;
                end else if (rx_done) begin
                    wr_en    = 1'b1;
                    rsp_load = 1'b1;
                    rsp_d    = RSP_ACK;
                    state_d  = SEND;
                end else if (tmo) begin
                    tmo_fire = 1'b1;
                    state_d  = IDLE;
                end
            end
            SEND: begin
                ovr_set = rx_done | rx_fail;
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                ovr_set = rx_done | rx_fail;
                state_d = WAIT;
            end
            WAIT: begin
                ovr_set = rx_done | rx_fail;
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Inter-byte timeout counter: runs only while a command is partially received.
    always_ff @(posedge clock) begin
        if (!reset || rx_done || rx_fail || (state_q != GET_ADDR && state_q != GET_DATA)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Registered outputs and command context.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cmd_wr_q    <= 1'b0;
            addr_q      <= '0;
            tx_data     <= 8'h00;
            wr_strobe   <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= 8'h00;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            cmd_wr_q    <= cmd_wr_d;
            wr_strobe   <= wr_en;
            timeout_err <= tmo_fire;
            overrun     <= overrun | ovr_set;
            if (addr_load) begin
                addr_q <= rx_addr;
            end
            if (wr_en) begin
                wr_addr <= addr_q;
                wr_data <= rx_data;
            end
            if (rsp_load) begin
                tx_data <= rsp_d;
            end
        end
    end

endmodule

// File: doc/uart_cmd_responder.md
# uart_cmd_responder

Byte-level command responder on the far side of the UART byte interface. It consumes received bytes (`rx_data`/`rx_done`/`rx_fail`) and parses a small register-access protocol against an internal register file. It answers every complete command through the transmit side (`send_data`/`start`/`busy`). It sits above the `uart` top and gives a host PC read/write access to control registers.

## Interface
- `ADDR_W`, 4, register address width; NUM_REGS = 2**ADDR_W, 8-bit registers.
- `TIMEOUT_CYCLES`, 100000, maximum clock cycles allowed between bytes of one command.
- `clock`  in  1  system clock, same domain as `uart`.
- `reset`  in  1  synchronous, active-low reset.
- `rx_data`  in  8  received byte, valid in the `rx_done` cycle.
- `rx_done`  in  1  one-cycle pulse per received byte.
- `rx_fail`  in  1  one-cycle pulse on a framing error.
- `tx_busy`  in  1  transmitter busy; wired to `uart.busy`.
- `tx_data`  out  8  response byte; wired to `send_data`.
- `tx_start`  out  1  one-cycle transmit request; wired to `start`.
- `wr_strobe`  out  1  one-cycle pulse when a register is written.
- `wr_addr`  out  ADDR_W  address of the write; valid with `wr_strobe`.
- `wr_data`  out  8  data of the write; valid with `wr_strobe`.
- `timeout_err`  out  1  one-cycle pulse when a partial command is abandoned.
- `overrun`  out  1  sticky flag: a byte arrived while a response was pending. Cleared only by reset.

## Operation
- Protocol:
  - Write = `'W'` (0x57), addr, data → ACK 0x06.
  - Read = `'R'` (0x52), addr → register value.
  - Any other first byte → NAK 0x15.
  - An addr byte with nonzero bits above ADDR_W → NAK, no write.
- States and transitions:
  - IDLE → GET_ADDR on a valid opcode.
  - IDLE → SEND(NAK) on an unknown opcode.
  - GET_ADDR → GET_DATA for a write, or → SEND for a read or a bad address.
  - GET_DATA → SEND(ACK).
  - SEND → HOLD → WAIT → IDLE.
- SEND: waits for `tx_busy`=0, then drives `tx_start`=1 for one cycle with `tx_data` set.
- HOLD: lasts one cycle; `tx_busy` is ignored so the transmitter has time to raise it.
- WAIT: remains until `tx_busy`=0, then goes to IDLE.
- `tx_data` holds its value until the next SEND.
- Register write:
  - The register and the `wr_*` outputs update on the clock edge of the data byte's `rx_done`.
  - `wr_strobe` is high in the following cycle.
- A read returns the register value sampled in the addr byte's `rx_done` cycle. A write and a read of the same address never overlap.
- `rx_fail` in GET_ADDR or GET_DATA: command dropped, go to SEND(NAK). In IDLE: go to SEND(NAK). In SEND/HOLD/WAIT: ignored, `overrun` set.
- `rx_done` in SEND/HOLD/WAIT: byte dropped, `overrun` set, state unchanged.
- `rx_done` and `rx_fail` in the same cycle: `rx_fail` wins.
- Timeout counter:
  - Cleared on every `rx_done`/`rx_fail` and in IDLE.
  - Counts in GET_ADDR/GET_DATA.
  - When it reaches TIMEOUT_CYCLES-1: `timeout_err` pulses, state goes to IDLE, no response is sent.
  - Counter width is clog2(TIMEOUT_CYCLES).

## Timing
- Reset (`reset`=0 at a clock edge) gives:
  - state IDLE;
  - all registers 0x00;
  - `tx_data`=0x00, `tx_start`=0;
  - `wr_strobe`=0, `wr_addr`=0, `wr_data`=0;
  - `timeout_err`=0, `overrun`=0.
- Reset mid-operation aborts everything. A `tx_start` already issued is not retracted; the `uart` reset is tied to the same signal.
- Response latency: the last byte's `rx_done` is at cycle N. `tx_start` is high at cycle N+1 if `tx_busy` was 0 at N+1; otherwise it is delayed.
- `tx_start` is never high in two consecutive cycles. It is never asserted while `tx_busy`=1.
- At most one response is outstanding. No command buffering.

## Structure
- Shared package `uart_pkg` holds:
  - constants `CMD_WR`=0x57, `CMD_RD`=0x52, `RSP_ACK`=0x06, `RSP_NAK`=0x15;
  - state enum `resp_state_t` {IDLE, GET_ADDR, GET_DATA, SEND, HOLD, WAIT}.
- One sub-module, `uart_regfile`:
  - NUM_REGS×8 storage;
  - synchronous write port;
  - combinational read port;
  - synchronous active-low reset to zero.
- The FSM, timeout counter and response mux stay in `uart_cmd_responder`.

## Test plan
- Write then read: bytes 0x57,0x03,0xA5 → `wr_strobe` with addr 3 and data 0xA5, `tx_data`=0x06. Then bytes 0x52,0x03 → `tx_data`=0xA5.
- Bad opcode and bad address: byte 0x41 → response 0x15. Bytes 0x52,0x13 → response 0x15, registers unchanged.
- Framing error: 0x57, then `rx_fail` pulse → response 0x15, no `wr_strobe`. Next byte 0x41 is parsed as an opcode.
- Timeout: 0x57,0x02, then silence for TIMEOUT_CYCLES → `timeout_err` pulses once, no `tx_start`. Then 0x52,0x02 → response 0x00.
- Busy/overrun: hold `tx_busy`=1 and send 0x52,0x00 → no `tx_start` until `tx_busy` falls. Extra byte 0x57 during the wait → `overrun`=1, byte dropped.
- Reset mid-command: 0x57,0x05, then `reset`=0 for one cycle, then 0xFF → response 0x15; all registers read back 0x00.
